// File: rtl/fifo_pkg.sv
// Shared constants and pointer-encoding helpers for the async FIFO write/read controllers.
package fifo_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int MAX_PTR_W  = 13;

  // Callers zero-extend narrower pointers; upper result bits then stay zero.
  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down), shared by both FIFO sides.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/wptr_ovf_chk.sv
// Simulation checker that flags the first write attempted while full (WPTR_OVF_STICKY_EN builds only).
`ifdef WPTR_OVF_STICKY_EN
module wptr_ovf_chk (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_ovf
);

  // The overflow flag is sticky, so its single rising edge marks the first overflow.
  a_first_ovf : assert property (@(posedge i_clk) disable iff (!i_rst_n) !$rose(i_ovf))
    else $warning("write FIFO overflow: write attempted while full");

endmodule
`endif

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer, full, almost-full and fill-level controller for the async FIFO.
// Optional sticky overflow output wr_ovf is enabled by defining WPTR_OVF_STICKY_EN.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level
`ifdef WPTR_OVF_STICKY_EN
  ,
  output logic              wr_ovf
`endif
);

  localparam int              PW        = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_THRESH = PW'(AFULL_THRESH);

  logic [ADDR_W:0]    r_wbin;
  logic [ADDR_W:0]    r_wgray;
  logic               r_full;
  logic               r_afull;
  logic [ADDR_W:0]    r_level;

  logic               w_accept;
  logic [ADDR_W:0]    w_wbin_next;
  logic [ADDR_W:0]    w_rbin;
  logic [ADDR_W:0]    w_level_next;
  logic [MAX_PTR_W-1:0] w_gray_wide;
  logic [MAX_PTR_W-1:0] w_full_pat;
  logic               w_full_next;

  gray2bin #(.W(PW)) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin)
  );

  assign w_accept     = wr_en & ~r_full;
  assign w_wbin_next  = r_wbin + PW'(w_accept);
  assign w_gray_wide  = bin2gray(MAX_PTR_W'(w_wbin_next));
  // Full when the next write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign w_full_pat   = MAX_PTR_W'({~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]});
  assign w_full_next  = (w_gray_wide == w_full_pat);
  assign w_level_next = w_wbin_next - w_rbin;

  // Pointer, flag and level state; everything folds the accepted write in on the same edge.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      r_wbin  <= '0;
      r_wgray <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_gray_wide[ADDR_W:0];
      r_full  <= w_full_next;
      r_afull <= (w_level_next >= AF_THRESH);
      r_level <= w_level_next;
    end
  end

  assign wr_accept   = w_accept;
  assign wr_addr     = r_wbin[ADDR_W-1:0];
  assign wr_ptr      = r_wgray;
  assign full        = r_full;
  assign almost_full = r_afull;
  assign wr_level    = r_level;

`ifdef WPTR_OVF_STICKY_EN
  logic r_ovf;

  // Sticky record of any write attempted while full; only reset clears it.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf | (wr_en & r_full);
    end
  end

  assign wr_ovf = r_ovf;

  wptr_ovf_chk u_ovf_chk (
    .i_clk   (wr_clk),
    .i_rst_n (wr_rst_n),
    .i_ovf   (r_ovf)
  );
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl (ADDR_W=4, AFULL_THRESH=12) against an occupancy-count model.
module tb_wptr_full_ctrl;

  localparam int AW = 4;

  logic          wr_clk = 1'b0;
  logic          wr_rst_n;
  logic          wr_en;
  logic [AW:0]   wq2_rptr;
  logic          wr_accept;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   wr_ptr;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
`ifdef WPTR_OVF_STICKY_EN
  logic          wr_ovf;
`endif

  wptr_full_ctrl #(.ADDR_W(AW), .AFULL_THRESH(12)) dut (
    .wr_clk      (wr_clk),
    .wr_rst_n    (wr_rst_n),
    .wr_en       (wr_en),
    .wq2_rptr    (wq2_rptr),
    .wr_accept   (wr_accept),
    .wr_addr     (wr_addr),
    .wr_ptr      (wr_ptr),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level)
`ifdef WPTR_OVF_STICKY_EN
    ,
    .wr_ovf      (wr_ovf)
`endif
  );

  always #5 wr_clk = ~wr_clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: total writes and reads ever made; everything else derives from their difference.
  int       m_w = 0;
  int       m_r = 0;
  logic     e_full = 1'b0;
  logic     e_af = 1'b0;
  logic [AW:0] e_lvl = '0;

  logic [15:0] dut_vec;
  assign dut_vec = {wr_ptr, wr_addr, full, almost_full, wr_level};

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] exp_vec();
    return {gray5(m_w), 4'(m_w % 16), e_full, e_af, e_lvl};
  endfunction

  task automatic set_rd(input int r);
    m_r = r;
    wq2_rptr = gray5(r);
  endtask

  task automatic tick();
    logic acc;
    int   occ;
    acc = wr_en & ~e_full;
    @(posedge wr_clk);
    if (!wr_rst_n) begin
      m_w = 0; e_full = 1'b0; e_af = 1'b0; e_lvl = '0;
    end else begin
      m_w    = m_w + (acc ? 1 : 0);
      occ    = m_w - m_r;
      e_lvl  = 5'(occ);
      e_full = (occ == 16);
      e_af   = (occ >= 12);
    end
    #1;
  endtask

  task automatic do_reset();
    wr_rst_n = 1'b0; wr_en = 1'b0; set_rd(0);
    tick();
    wr_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    wr_rst_n = 1'b0; wr_en = 1'b1; set_rd(0);
    tick(); tick();
    n_vec++;
    if (dut_vec !== 16'h0000) begin
      n_err++; $display("FAIL reset_state: got %h want 0000", dut_vec);
    end
    n_vec++;
    if (wr_accept !== 1'b1) begin
      n_err++; $display("FAIL reset_accept: got %b want 1", wr_accept);
    end
    wr_rst_n = 1'b1;
    tick(); tick(); tick();
    wr_en = 1'b0;
    #1 wr_rst_n = 1'b0;
    #2 wr_rst_n = 1'b1;
    tick();
    n_vec++;
    if (dut_vec !== exp_vec() || wr_addr !== 4'd3) begin
      n_err++; $display("FAIL reset_glitch: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_fill();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_vec++;
      if (wr_accept !== 1'b1) begin
        n_err++; $display("FAIL fill_accept[%0d]: got %b want 1", i, wr_accept);
      end
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL fill[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      if (i == 10 || i == 11) begin
        n_vec++;
        if (almost_full !== (i == 11)) begin
          n_err++; $display("FAIL fill_afull_edge[%0d]: got %b want %b", i, almost_full, i == 11);
        end
      end
    end
    n_vec++;
    if (full !== 1'b1 || wr_ptr !== 5'b11000 || wr_level !== 5'd16) begin
      n_err++; $display("FAIL fill_end: got full=%b ptr=%b lvl=%0d want 1 11000 16", full, wr_ptr, wr_level);
    end
  endtask

  task automatic test_write_full();
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (wr_accept !== 1'b0) begin
        n_err++; $display("FAIL full_accept[%0d]: got %b want 0", i, wr_accept);
      end
      tick();
      n_vec++;
      if (wr_ptr !== 5'b11000 || wr_addr !== 4'd0 || full !== 1'b1 || dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL full_hold[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
`ifdef WPTR_OVF_STICKY_EN
      n_vec++;
      if (wr_ovf !== 1'b1) begin
        n_err++; $display("FAIL ovf_sticky[%0d]: got %b want 1", i, wr_ovf);
      end
`endif
    end
  endtask

  task automatic test_drain();
    wr_en = 1'b0;
    set_rd(4);
    tick();
    n_vec++;
    if (full !== 1'b0 || wr_level !== 5'd12 || almost_full !== 1'b1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL drain_4: got %h want %h", dut_vec, exp_vec());
    end
    set_rd(5);
    tick();
    n_vec++;
    if (almost_full !== 1'b0 || wr_level !== 5'd11 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL drain_5: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    do_reset();
    wr_en = 1'b1;
    prev = wr_ptr;
    for (int i = 0; i < 40; i++) begin
      set_rd((m_w >= 2) ? m_w - 2 : 0);
      tick();
      n_vec++;
      if (dut_vec !== exp_vec() || full !== 1'b0) begin
        n_err++; $display("FAIL wrap[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      n_vec++;
      if ($countones(prev ^ wr_ptr) != 1) begin
        n_err++; $display("FAIL wrap_onebit[%0d]: got %b -> %b want one toggle", i, prev, wr_ptr);
      end
      if (m_w == 32) begin
        n_vec++;
        if (prev !== 5'b10000 || wr_ptr !== 5'b00000) begin
          n_err++; $display("FAIL wrap_ptr: got %b -> %b want 10000 -> 00000", prev, wr_ptr);
        end
      end
      prev = wr_ptr;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    wr_rst_n = 1'b0;
    tick();
    n_vec++;
    if (dut_vec !== 16'h0000 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL midreset_state: got %h want 0000", dut_vec);
    end
    wr_rst_n = 1'b1;
    #1;
    n_vec++;
    if (wr_accept !== 1'b1 || wr_addr !== 4'd0) begin
      n_err++; $display("FAIL midreset_first: got acc=%b addr=%0d want 1 0", wr_accept, wr_addr);
    end
    tick();
    n_vec++;
    if (wr_addr !== 4'd1 || dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL midreset_next: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    int adv;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      adv = $urandom_range(0, (m_w - m_r > 2) ? 2 : m_w - m_r);
      if ((i % 64) > 40) adv = 0;
      set_rd(m_r + adv);
      #1;
      n_vec++;
      if (wr_accept !== (wr_en & ~e_full)) begin
        n_err++; $display("FAIL rand_accept[%0d]: got %b want %b", i, wr_accept, wr_en & ~e_full);
      end
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rand[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    wr_rst_n = 1'b0;
    wr_en    = 1'b0;
    wq2_rptr = '0;
    test_reset();
    test_fill();
    test_write_full();
    test_drain();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
Name: wptr_full_ctrl

Overview:
Parametrised write-side pointer and full/almost-full controller for the asynchronous FIFO, operating entirely in the write clock domain. It keeps a binary write count and a registered Gray write pointer for the read-domain synchronizer. It compares its next Gray pointer against the 2-flop-synchronized read pointer (wq2_rptr) to produce a registered full flag. It also produces fill level and almost-full, so the write source can throttle before overflow.

Parameters:
ADDR_W, 4, RAM address width; FIFO depth = 2**ADDR_W; legal range 2..12.
AFULL_THRESH, 12, level (entries) at or above which almost_full asserts; legal 1..2**ADDR_W.

Ports:
wr_clk  in  1  write-domain clock, all state on rising edge.
wr_rst_n  in  1  synchronous active-low reset.
wr_en  in  1  write request from source.
wq2_rptr  in  ADDR_W+1  read Gray pointer, already synchronized into wr_clk.
wr_accept  out  1  combinational: wr_en & ~full; RAM write strobe.
wr_addr  out  ADDR_W  RAM write address = binary count low bits (registered state).
wr_ptr  out  ADDR_W+1  registered Gray write pointer to read-domain synchronizer.
full  out  1  registered full flag.
almost_full  out  1  registered, level >= AFULL_THRESH.
wr_level  out  ADDR_W+1  registered fill level, 0..2**ADDR_W (pessimistic: lags reads).

Behaviour:
- Reset: one clock and a synchronous active-low reset only. wr_rst_n is sampled only on the rising edge of wr_clk; a low pulse between edges has no effect. On reset: wbin=0, wr_ptr=0, full=0, almost_full=0, wr_level=0. Consequently wr_addr=0 and wr_accept=wr_en.
- Reset asserted mid-operation: the state is discarded in the same edge. An in-flight wr_en on that edge is not counted.
- Next-state, all in ADDR_W+1 bits with modulo wrap:
  - wbin_next = wbin + wr_accept.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Full test: full <= (wgray_next == {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]}).
  - Full asserts on the same edge that accepts the write filling the last slot. There is no one-cycle gap.
- Full is recomputed every cycle, including while full. Deassertion occurs on the first edge after wq2_rptr advances.
- Writes while full: wr_accept=0, pointers hold, no RAM write.
- Level and almost-full:
  - rbin = gray-to-binary(wq2_rptr).
  - wr_level <= wbin_next - rbin, modulo 2**(ADDR_W+1); the result is always 0..2**ADDR_W.
  - almost_full <= (wbin_next - rbin) >= AFULL_THRESH.
- Latency: wr_addr changes the edge after an accepted write. wr_ptr/full/level/almost_full reflect the accepted write on that same edge.
- Wrap-around: wbin rolls 2**(ADDR_W+1)-1 -> 0, and wr_ptr follows the Gray sequence. Exactly one wr_ptr bit changes per accepted write; this must hold for CDC.
- Simultaneous write and read-pointer advance in the same cycle: both are folded into the next-state computation; level is unchanged if both advance by one.
- Input wq2_rptr is assumed Gray-legal; no checking is performed.

Optional Feature:
WPTR_OVF_STICKY_EN
- Defined: adds output wr_ovf (1 bit, registered). It sets on any edge where wr_en & full, and is sticky until wr_rst_n low. Simulation-only assertion flags the first overflow.
- Undefined: port and logic are absent. Write attempts while full are silently dropped.

Decomposition:
- Package fifo_pkg holds:
  - default ADDR_W constant;
  - function bin2gray(width-generic via ADDR_W+1);
  - localparam DEPTH = 2**ADDR_W.
- One sub-module: gray2bin (parametrised width W). It is combinational XOR-prefix and is reused by the read-side controller for rptr/empty.
- Everything else stays flat in wptr_full_ctrl.

Test Plan:
All scenarios use ADDR_W=4, AFULL_THRESH=12.
1. Reset: hold wr_rst_n=0 for 2 edges with wr_en=1, wq2_rptr=0 -> wr_ptr=0, wr_addr=0, full=0, wr_level=0. Pulse wr_rst_n low between edges -> no state change.
2. Fill: wq2_rptr=0, wr_en=1 for 16 cycles -> the 16th accepting edge gives full=1, wr_ptr=5'b11000, wr_level=16. almost_full rises on the 12th accepting edge.
3. Write while full: wr_en=1 for 3 more cycles -> wr_accept=0, wr_ptr stays 5'b11000, wr_addr stays 0. With WPTR_OVF_STICKY_EN, wr_ovf=1 and stays 1.
4. Drain release: set wq2_rptr=gray(4)=5'b00110 -> next edge full=0, wr_level=12, almost_full=1. Set wq2_rptr=gray(5)=5'b00111 -> almost_full=0, level=11.
5. Wrap: read pointer trails by 2, 40 continuous writes. wr_addr wraps 15->0. wr_ptr goes gray(31)=5'b10000 -> 5'b00000. Exactly one bit toggles per write. full is never asserted.
6. Reset mid-fill: after 9 writes, wr_rst_n=0 on one edge with wr_en=1 -> all outputs 0 next edge. The following write lands at wr_addr=0.
